// File: rtl/scroll_msg_display_pkg.sv
// scroll_pkg: shared constants for the scrolling message display.
//   SYM_W      symbol width ([4] = blank flag, [3:0] = hex digit)
//   SYM_BLANK  symbol that renders as an unlit digit
//   SEG_OFF    active-low segment pattern with every segment off
//   MSG_RST*   power-up message image ("dE1" followed by blanks)
package scroll_pkg;

  localparam int             SYM_W     = 5;
  localparam logic [SYM_W-1:0] SYM_BLANK = 5'h10;
  localparam logic [6:0]     SEG_OFF   = 7'h7F;

  localparam logic [SYM_W-1:0] MSG_RST0 = 5'h0D;
  localparam logic [SYM_W-1:0] MSG_RST1 = 5'h0E;
  localparam logic [SYM_W-1:0] MSG_RST2 = 5'h01;

  // Reset-image symbol for a given message slot.
  function automatic logic [SYM_W-1:0] rst_sym(input int slot);
    case (slot)
      0:       rst_sym = MSG_RST0;
      1:       rst_sym = MSG_RST1;
      2:       rst_sym = MSG_RST2;
      default: rst_sym = SYM_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/scroll_msg_display_if.sv
// scroll_msg_display_if: control/write/display bundle of the scroller.
//   run, dir, speed          scroll control (from switches/keys)
//   wr_en, wr_addr, wr_data  message write port
//   seg, offset, step        display outputs
// master = board/controller side, slave = scroll_msg_display.
interface scroll_msg_display_if
  import scroll_pkg::*;
#(
  parameter int DIGITS = 6,
  parameter int AW     = 3
);
  logic                run;
  logic                dir;
  logic [1:0]          speed;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [SYM_W-1:0]    wr_data;
  logic [7*DIGITS-1:0] seg;
  logic [AW-1:0]       offset;
  logic                step;

  modport master (
    output run, dir, speed, wr_en, wr_addr, wr_data,
    input  seg, offset, step
  );

  modport slave (
    input  run, dir, speed, wr_en, wr_addr, wr_data,
    output seg, offset, step
  );
endinterface

// File: rtl/scroll_msg_display_seg7_hex_decode.sv
// seg7_hex_decode: combinational symbol to 7-segment decoder.
//   sym_i  5-bit symbol; bit 4 set blanks the digit
//   seg_o  active-low segments, bit order gfedcba
module seg7_hex_decode
  import scroll_pkg::*;
(
  input  logic [SYM_W-1:0] sym_i,
  output logic [6:0]       seg_o
);
  always_comb begin
    seg_o = SEG_OFF;
    if (!sym_i[4]) begin
      case (sym_i[3:0])
        4'h0: seg_o = 7'h40;
        4'h1: seg_o = 7'h79;
        4'h2: seg_o = 7'h24;
        4'h3: seg_o = 7'h30;
        4'h4: seg_o = 7'h19;
        4'h5: seg_o = 7'h12;
        4'h6: seg_o = 7'h02;
        4'h7: seg_o = 7'h78;
        4'h8: seg_o = 7'h00;
        4'h9: seg_o = 7'h10;
        4'hA: seg_o = 7'h08;
        4'hB: seg_o = 7'h03;
        4'hC: seg_o = 7'h46;
        4'hD: seg_o = 7'h21;
        4'hE: seg_o = 7'h06;
        4'hF: seg_o = 7'h0E;
        default: seg_o = SEG_OFF;
      endcase
    end
  end
endmodule

// File: rtl/scroll_msg_display.sv
// scroll_msg_display: scrolling message driver for a bank of active-low
// 7-segment digits. A circular buffer of MSG_LEN symbols is shown through
// a DIGITS-wide window whose start index advances once per prescaler step.
//   CLOCK_50  system clock
//   reset     synchronous active-high reset (restores message image too)
//   bus       scroll_msg_display_if.slave (run/dir/speed, write port,
//             seg/offset/step outputs)
// Build option: SCROLL_BOUNCE_EN replaces wrap-around with ping-pong
// scrolling driven by an internal direction register (dir port ignored).
module scroll_msg_display
  import scroll_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int DIGITS   = 6,
  parameter int MSG_LEN  = 8,
  parameter int AW       = $clog2(MSG_LEN)
)(
  input logic                  CLOCK_50,
  input logic                  reset,
  scroll_msg_display_if.slave  bus
);
  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]       offset_q, offset_d;
  logic                step_q;
  logic                tick;
  logic [31:0]         lim;
  logic [SYM_W-1:0]    msg_q [MSG_LEN];
  logic [7*DIGITS-1:0] seg_q, seg_d;

  // Prescaler. The >= compare lets a speed-up mid-count fire immediately.
  always_comb begin
    lim   = (32'(TICK_DIV) >> bus.speed) - 32'd1;
    tick  = bus.run && (32'(cnt_q) >= lim);
    cnt_d = cnt_q;
    if (bus.run) cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

`ifdef SCROLL_BOUNCE_EN
  logic dir_q, dir_d;
  logic unused_dir;
  assign unused_dir = bus.dir;

  always_comb begin
    dir_d    = dir_q;
    offset_d = offset_q;
    if (tick && (MSG_LEN > DIGITS)) begin
      if (!dir_q) begin
        if (offset_q == AW'(MSG_LEN - DIGITS)) begin
          dir_d    = 1'b1;
          offset_d = offset_q - 1'b1;
        end else begin
          offset_d = offset_q + 1'b1;
        end
      end else begin
        if (offset_q == '0) begin
          dir_d    = 1'b0;
          offset_d = offset_q + 1'b1;
        end else begin
          offset_d = offset_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) dir_q <= 1'b0;
    else       dir_q <= dir_d;
  end
`else
  always_comb begin
    offset_d = offset_q;
    if (tick) begin
      if (!bus.dir)
        offset_d = (offset_q == AW'(MSG_LEN - 1)) ? '0 : offset_q + 1'b1;
      else
        offset_d = (offset_q == '0) ? AW'(MSG_LEN - 1) : offset_q - 1'b1;
    end
  end
`endif

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cnt_q    <= '0;
      offset_q <= '0;
      step_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      offset_q <= offset_d;
      step_q   <= tick;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < MSG_LEN; i++) msg_q[i] <= rst_sym(i);
    end else if (bus.wr_en && (32'(bus.wr_addr) < 32'(MSG_LEN))) begin
      msg_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // While reset is high the decoders see the reset image at offset 0, so
  // seg_q lands on the reset picture at the same edge as everything else.
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    logic [AW-1:0]    win_idx;
    logic [SYM_W-1:0] sym;

    assign win_idx = AW'((32'(offset_q) + 32'(DIGITS - 1 - k)) % 32'(MSG_LEN));
    assign sym     = reset ? rst_sym(DIGITS - 1 - k) : msg_q[win_idx];

    seg7_hex_decode u_dec (
      .sym_i (sym),
      .seg_o (seg_d[7*k +: 7])
    );
  end

  always_ff @(posedge CLOCK_50) begin
    seg_q <= seg_d;
  end

  assign bus.seg    = seg_q;
  assign bus.offset = offset_q;
  assign bus.step   = step_q;

endmodule

// File: tb/tb_scroll_msg_display.sv
// tb_scroll_msg_display: directed self-checking bench for scroll_msg_display
// with TICK_DIV=8, DIGITS=6, MSG_LEN=8.
module tb_scroll_msg_display;

  localparam int TICK_DIV = 8;
  localparam int DIGITS   = 6;
  localparam int MSG_LEN  = 8;
  localparam int AW       = 3;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic [4:0] m [MSG_LEN];

  scroll_msg_display_if #(.DIGITS(DIGITS), .AW(AW)) bus ();

  scroll_msg_display #(
    .TICK_DIV (TICK_DIV),
    .DIGITS   (DIGITS),
    .MSG_LEN  (MSG_LEN),
    .AW       (AW)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] glyph(input logic [4:0] s);
    logic [6:0] g;
    if (s[4]) return 7'b1111111;
    case (s[3:0])
      4'h0: g = 7'b1000000;  4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;  4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;  4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;  4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;  4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;  4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;  4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;  default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  function automatic logic [7*DIGITS-1:0] exp_seg(input int off);
    logic [7*DIGITS-1:0] r;
    for (int k = 0; k < DIGITS; k++)
      r[7*k +: 7] = glyph(m[(off + DIGITS - 1 - k) % MSG_LEN]);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < MSG_LEN; i++) m[i] = 5'h10;
    m[0] = 5'h0D; m[1] = 5'h0E; m[2] = 5'h01;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns the number of edges until step is seen, or -1 on timeout.
  task automatic wait_step(input int budget, output int cyc);
    int i;
    i   = 0;
    cyc = -1;
    while (cyc < 0 && i < budget) begin
      @(posedge clk);
      #1;
      i++;
      if (bus.step === 1'b1) cyc = i;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.wr_en = 1'b0;
    tick_n(2);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    bus.run = 1'b0;
    do_reset();
    n_tests++;
    if (bus.offset !== 3'd0) begin
      n_fail++; $display("FAIL reset_offset: got %0d want 0", bus.offset);
    end
    n_tests++;
    if (bus.step !== 1'b0) begin
      n_fail++; $display("FAIL reset_step: got %b want 0", bus.step);
    end
    n_tests++;
    if (bus.seg[41:35] !== 7'b0100001) begin
      n_fail++; $display("FAIL reset_digit5: got %b want 0100001", bus.seg[41:35]);
    end
    n_tests++;
    if (bus.seg[34:28] !== 7'b0000110) begin
      n_fail++; $display("FAIL reset_digit4: got %b want 0000110", bus.seg[34:28]);
    end
    n_tests++;
    if (bus.seg[27:21] !== 7'b1111001) begin
      n_fail++; $display("FAIL reset_digit3: got %b want 1111001", bus.seg[27:21]);
    end
    n_tests++;
    if (bus.seg[20:0] !== {21{1'b1}}) begin
      n_fail++; $display("FAIL reset_blank: got %h want 1fffff", bus.seg[20:0]);
    end
  endtask

  task automatic test_left_scroll();
    int cyc;
    int exp_cyc;
    bus.run = 1'b1; bus.dir = 1'b0; bus.speed = 2'd0;
    for (int s = 1; s <= 8; s++) begin
      exp_cyc = (s == 4) ? 7 : 8;
      wait_step(20, cyc);
      n_tests++;
      if (cyc !== exp_cyc) begin
        n_fail++; $display("FAIL left_period: step %0d got %0d cycles want %0d", s, cyc, exp_cyc);
      end
      n_tests++;
      if (bus.offset !== 3'(s % MSG_LEN)) begin
        n_fail++; $display("FAIL left_offset: step %0d got %0d want %0d", s, bus.offset, s % MSG_LEN);
      end
      if (s == 3) begin
        tick_n(1);
        n_tests++;
        if (bus.seg !== exp_seg(3)) begin
          n_fail++; $display("FAIL left_seg3: got %h want %h", bus.seg, exp_seg(3));
        end
      end
    end
    tick_n(1);
    n_tests++;
    if (bus.seg !== exp_seg(0)) begin
      n_fail++; $display("FAIL left_wrap_seg: got %h want %h", bus.seg, exp_seg(0));
    end
  endtask

  task automatic test_right_speed();
    int cyc;
    logic bad;
    bus.dir = 1'b1;
    wait_step(20, cyc);
    n_tests++;
    if (cyc !== 7 || bus.offset !== 3'd7) begin
      n_fail++; $display("FAIL right_wrap: got cyc=%0d off=%0d want cyc=7 off=7", cyc, bus.offset);
    end
    bus.speed = 2'd2;
    for (int s = 0; s < 2; s++) begin
      wait_step(10, cyc);
      n_tests++;
      if (cyc !== 2 || bus.offset !== 3'(6 - s)) begin
        n_fail++; $display("FAIL speed2: got cyc=%0d off=%0d want cyc=2 off=%0d", cyc, bus.offset, 6 - s);
      end
    end
    bus.speed = 2'd0;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick_n(1);
      if (bus.step !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad !== 1'b0) begin
      n_fail++; $display("FAIL speed0_nostep: got early step want none");
    end
    bus.speed = 2'd3;
    wait_step(4, cyc);
    n_tests++;
    if (cyc !== 1 || bus.offset !== 3'd4) begin
      n_fail++; $display("FAIL speed_up_immediate: got cyc=%0d off=%0d want cyc=1 off=4", cyc, bus.offset);
    end
    bus.run = 1'b0; bus.speed = 2'd0; bus.dir = 1'b0;
  endtask

  task automatic test_write();
    bus.run = 1'b0; bus.dir = 1'b0; bus.speed = 2'd0;
    do_reset();
    bus.wr_en = 1'b1; bus.wr_addr = 3'd3; bus.wr_data = 5'h0A;
    tick_n(1);
    bus.wr_en = 1'b0;
    m[3] = 5'h0A;
    n_tests++;
    if (bus.seg[20:14] !== 7'b1111111) begin
      n_fail++; $display("FAIL write_latency: got %b want 1111111", bus.seg[20:14]);
    end
    tick_n(1);
    n_tests++;
    if (bus.seg[20:14] !== 7'b0001000) begin
      n_fail++; $display("FAIL write_glyph_A: got %b want 0001000", bus.seg[20:14]);
    end
    n_tests++;
    if (bus.seg !== exp_seg(0)) begin
      n_fail++; $display("FAIL write_seg: got %h want %h", bus.seg, exp_seg(0));
    end
    // write landing on the same edge as a step
    bus.run = 1'b1;
    tick_n(7);
    bus.wr_en = 1'b1; bus.wr_addr = 3'd6; bus.wr_data = 5'h05;
    tick_n(1);
    bus.wr_en = 1'b0; bus.run = 1'b0;
    m[6] = 5'h05;
    n_tests++;
    if (bus.step !== 1'b1 || bus.offset !== 3'd1) begin
      n_fail++; $display("FAIL write_step: got step=%b off=%0d want step=1 off=1", bus.step, bus.offset);
    end
    tick_n(1);
    n_tests++;
    if (bus.seg !== exp_seg(1)) begin
      n_fail++; $display("FAIL write_step_seg: got %h want %h", bus.seg, exp_seg(1));
    end
    // blank flag overrides the hex nibble
    bus.wr_en = 1'b1; bus.wr_addr = 3'd2; bus.wr_data = 5'h1C;
    tick_n(1);
    bus.wr_en = 1'b0;
    m[2] = 5'h1C;
    tick_n(1);
    n_tests++;
    if (bus.seg[34:28] !== 7'b1111111 || bus.seg !== exp_seg(1)) begin
      n_fail++; $display("FAIL write_blank: got %h want %h", bus.seg, exp_seg(1));
    end
  endtask

  task automatic test_freeze();
    int cyc;
    logic bad;
    bus.run = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick_n(1);
      if (bus.step !== 1'b0 || bus.offset !== 3'd1) bad = 1'b1;
    end
    n_tests++;
    if (bad !== 1'b0) begin
      n_fail++; $display("FAIL freeze: got step/offset change (off=%0d) want off=1 no step", bus.offset);
    end
    bus.run = 1'b1; bus.dir = 1'b0;
    wait_step(20, cyc);
    n_tests++;
    if (cyc !== 8 || bus.offset !== 3'd2) begin
      n_fail++; $display("FAIL freeze_resume: got cyc=%0d off=%0d want cyc=8 off=2", cyc, bus.offset);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    tick_n(3);
    rst = 1'b1;
    bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 5'h07;
    tick_n(1);
    rst = 1'b0; bus.wr_en = 1'b0;
    model_reset();
    n_tests++;
    if (bus.offset !== 3'd0 || bus.step !== 1'b0) begin
      n_fail++; $display("FAIL midreset_state: got off=%0d step=%b want 0 0", bus.offset, bus.step);
    end
    n_tests++;
    if (bus.seg !== exp_seg(0)) begin
      n_fail++; $display("FAIL midreset_seg: got %h want %h", bus.seg, exp_seg(0));
    end
    wait_step(20, cyc);
    n_tests++;
    if (cyc !== 8 || bus.offset !== 3'd1) begin
      n_fail++; $display("FAIL midreset_prescaler: got cyc=%0d off=%0d want cyc=8 off=1", cyc, bus.offset);
    end
    tick_n(1);
    n_tests++;
    if (bus.seg !== exp_seg(1)) begin
      n_fail++; $display("FAIL midreset_msg: got %h want %h", bus.seg, exp_seg(1));
    end
    bus.run = 1'b0;
  endtask

`ifdef SCROLL_BOUNCE_EN
  task automatic test_bounce();
    int cyc;
    int i;
    int exp_off [5];
    exp_off = '{1, 2, 1, 0, 1};
    bus.run = 1'b0;
    do_reset();
    bus.run = 1'b1; bus.speed = 2'd2;
    for (int s = 0; s < 5; s++) begin
      cyc = -1;
      i = 0;
      while (cyc < 0 && i < 10) begin
        bus.dir = ~bus.dir;
        @(posedge clk);
        #1;
        i++;
        if (bus.step === 1'b1) cyc = i;
      end
      n_tests++;
      if (cyc !== 2 || bus.offset !== 3'(exp_off[s])) begin
        n_fail++; $display("FAIL bounce: step %0d got cyc=%0d off=%0d want cyc=2 off=%0d", s, cyc, bus.offset, exp_off[s]);
      end
    end
    bus.run = 1'b0;
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.run = 1'b0; bus.dir = 1'b0; bus.speed = 2'd0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    model_reset();

    test_reset();
`ifndef SCROLL_BOUNCE_EN
    test_left_scroll();
    test_right_speed();
`endif
    test_write();
    test_freeze();
    test_reset_mid();
`ifdef SCROLL_BOUNCE_EN
    test_bounce();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
